// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating bubble counter for performance debug.
module idex_stage #(
    parameter int N    = 64,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    rd1_d,
    input  logic [N-1:0]    rd2_d,
    input  logic [N-1:0]    imm_d,
    input  logic [4:0]      ra1_d,
    input  logic [4:0]      ra2_d,
    input  logic            uses_ra2_d,
    input  logic [4:0]      wa_d,
    input  logic [2:0]      ex_ctrl_d,
    input  logic [2:0]      mem_ctrl_d,
    input  logic [1:0]      wb_ctrl_d,
    input  logic            valid_d,
    input  logic            flush_i,
    output logic            stall_o,
    output logic [N-1:0]    rd1_e,
    output logic [N-1:0]    rd2_e,
    output logic [N-1:0]    imm_e,
    output logic [4:0]      ra1_e,
    output logic [4:0]      ra2_e,
    output logic [4:0]      wa_e,
    output logic [2:0]      ex_ctrl_e,
    output logic [2:0]      mem_ctrl_e,
    output logic [1:0]      wb_ctrl_e,
    output logic            valid_e,
    output logic [CNTW-1:0] stall_cnt
);

    logic load_use;
    logic bubble;
    logic count_bubble;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (&v)
            return v;
        return v + {{(CNTW-1){1'b0}}, 1'b1};
    endfunction

    // X31 is XZR: a load targeting it is dropped by the register file, so it
    // can never feed the decode instruction.
    always_comb begin
        load_use = valid_e & mem_ctrl_e[1] & (wa_e != 5'd31) & valid_d &
                   ((wa_e == ra1_d) | (uses_ra2_d & (wa_e == ra2_d)));
    end

    // A flushed decode instruction is discarded, so it is never held.
    assign stall_o      = load_use & ~flush_i & ~reset;
    assign bubble       = flush_i | load_use;
    assign count_bubble = load_use & ~flush_i;

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            ra1_e      <= '0;
            ra2_e      <= '0;
            wa_e       <= '0;
            ex_ctrl_e  <= '0;
            mem_ctrl_e <= '0;
            wb_ctrl_e  <= '0;
            valid_e    <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            rd1_e <= rd1_d;
            rd2_e <= rd2_d;
            imm_e <= imm_d;
            ra1_e <= ra1_d;
            ra2_e <= ra2_d;
            wa_e  <= wa_d;
            if (bubble) begin
                ex_ctrl_e  <= '0;
                mem_ctrl_e <= '0;
                wb_ctrl_e  <= '0;
                valid_e    <= 1'b0;
            end else begin
                ex_ctrl_e  <= ex_ctrl_d & {3{valid_d}};
                mem_ctrl_e <= mem_ctrl_d & {3{valid_d}};
                wb_ctrl_e  <= wb_ctrl_d & {2{valid_d}};
                valid_e    <= valid_d;
            end
            if (count_bubble)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed scenarios plus randomized traffic against an
// instruction-level model of the EX slot. A narrow counter exercises saturation.
module tb_idex_stage;

    localparam int N    = 64;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    rd1_d, rd2_d, imm_d;
    logic [4:0]      ra1_d, ra2_d, wa_d;
    logic            uses_ra2_d;
    logic [2:0]      ex_ctrl_d, mem_ctrl_d;
    logic [1:0]      wb_ctrl_d;
    logic            valid_d, flush_i;
    logic            stall_o;
    logic [N-1:0]    rd1_e, rd2_e, imm_e;
    logic [4:0]      ra1_e, ra2_e, wa_e;
    logic [2:0]      ex_ctrl_e, mem_ctrl_e;
    logic [1:0]      wb_ctrl_e;
    logic            valid_e;
    logic [CNTW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Model of the instruction sitting in EX, plus the bubble tally.
    logic [N-1:0] m_rd1, m_rd2, m_imm;
    logic [4:0]   m_ra1, m_ra2, m_wa;
    logic [2:0]   m_ex, m_mem;
    logic [1:0]   m_wb;
    logic         m_valid;
    int           m_cnt;

    idex_stage #(.N(N), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .uses_ra2_d(uses_ra2_d), .wa_d(wa_d),
        .ex_ctrl_d(ex_ctrl_d), .mem_ctrl_d(mem_ctrl_d), .wb_ctrl_d(wb_ctrl_d),
        .valid_d(valid_d), .flush_i(flush_i), .stall_o(stall_o),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
        .ra1_e(ra1_e), .ra2_e(ra2_e), .wa_e(wa_e),
        .ex_ctrl_e(ex_ctrl_e), .mem_ctrl_e(mem_ctrl_e), .wb_ctrl_e(wb_ctrl_e),
        .valid_e(valid_e), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // The decode instruction depends on a real (non-XZR) load sitting in EX.
    function automatic logic model_hazard();
        logic ex_is_load, reads_dest;
        ex_is_load = m_valid && m_mem[1] && (m_wa != 5'd31);
        reads_dest = (ra1_d == m_wa) || (uses_ra2_d && (ra2_d == m_wa));
        return ex_is_load && valid_d && reads_dest;
    endfunction

    function automatic logic model_stall();
        return model_hazard() && !flush_i && !reset;
    endfunction

    task automatic step();
        logic h;
        @(posedge clk);
        h = model_hazard();
        if (reset) begin
            {m_rd1, m_rd2, m_imm} = '0;
            {m_ra1, m_ra2, m_wa}  = '0;
            {m_ex, m_mem, m_wb}   = '0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_d;
            m_ra1 = ra1_d; m_ra2 = ra2_d; m_wa = wa_d;
            if (flush_i || h) begin
                {m_ex, m_mem, m_wb} = '0;
                m_valid = 1'b0;
                if (!flush_i && m_cnt < CMAX)
                    m_cnt++;
            end else begin
                m_ex    = valid_d ? ex_ctrl_d : 3'b000;
                m_mem   = valid_d ? mem_ctrl_d : 3'b000;
                m_wb    = valid_d ? wb_ctrl_d : 2'b00;
                m_valid = valid_d;
            end
        end
        #1;
    endtask

    task automatic set_instr(input logic [4:0] ra1, input logic [4:0] ra2,
                             input logic uses2, input logic [4:0] wa,
                             input logic [2:0] ex, input logic [2:0] mem,
                             input logic [1:0] wb, input logic valid);
        rd1_d = {$urandom, $urandom};
        rd2_d = {$urandom, $urandom};
        imm_d = {$urandom, $urandom};
        ra1_d = ra1; ra2_d = ra2; uses_ra2_d = uses2; wa_d = wa;
        ex_ctrl_d = ex; mem_ctrl_d = mem; wb_ctrl_d = wb;
        valid_d = valid; flush_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_instr(5'd0, 5'd0, 1'b0, 5'd0, 3'b000, 3'b000, 2'b00, 1'b0);
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_instr(5'd3, 5'd4, 1'b1, 5'd9, 3'b111, 3'b111, 2'b11, 1'b1);
        reset = 1'b1;
        step();
        tests++;
        if ({rd1_e, rd2_e, imm_e, ra1_e, ra2_e, wa_e, ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e} !== '0) begin
            fails++;
            $display("FAIL reset_regs: got %h required 0", {rd1_e, rd2_e, imm_e, ra1_e, ra2_e, wa_e, ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e});
        end
        tests++;
        if (stall_cnt !== '0 || stall_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt_stall: stall_cnt=%0d stall_o=%b required 0/0", stall_cnt, stall_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_straight_line();
        do_reset();
        set_instr(5'd2, 5'd3, 1'b1, 5'd1, 3'b000, 3'b000, 2'b10, 1'b1);
        rd1_d = 64'd2; rd2_d = 64'd3;
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            fails++; $display("FAIL add_stall: stall_o=%b required 0", stall_o);
        end
        step();
        tests++;
        if (rd1_e !== 64'd2 || rd2_e !== 64'd3 || wa_e !== 5'd1 || wb_ctrl_e !== 2'b10 || valid_e !== 1'b1) begin
            fails++;
            $display("FAIL add_capture: rd1=%0d rd2=%0d wa=%0d wb=%b v=%b required 2 3 1 10 1",
                     rd1_e, rd2_e, wa_e, wb_ctrl_e, valid_e);
        end
        // An invalid slot must never carry a live control bit.
        set_instr(5'd2, 5'd3, 1'b1, 5'd1, 3'b111, 3'b111, 2'b11, 1'b0);
        step();
        tests++;
        if ({ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e} !== 9'd0) begin
            fails++;
            $display("FAIL invalid_gating: ctrl=%b required 0", {ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e});
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd5, 5'd7, 1'b1, 5'd6, 3'b010, 3'b000, 2'b10, 1'b1);
        #1;
        tests++;
        if (stall_o !== 1'b1) begin
            fails++; $display("FAIL lu_stall: stall_o=%b required 1", stall_o);
        end
        step();
        tests++;
        if ({ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e} !== 9'd0 || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL lu_bubble: ctrl=%b cnt=%0d required 0 and 1", {ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e}, stall_cnt);
        end
        tests++;
        if (stall_o !== 1'b0) begin
            fails++; $display("FAIL lu_release: stall_o=%b required 0", stall_o);
        end
        step();
        tests++;
        if (wa_e !== 5'd6 || ra1_e !== 5'd5 || valid_e !== 1'b1 || wb_ctrl_e !== 2'b10 || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL lu_advance: wa=%0d ra1=%0d v=%b wb=%b cnt=%0d required 6 5 1 10 1",
                     wa_e, ra1_e, valid_e, wb_ctrl_e, stall_cnt);
        end
    endtask

    task automatic test_ra2_gating();
        do_reset();
        set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd8, 5'd5, 1'b0, 5'd6, 3'b100, 3'b000, 2'b10, 1'b1);
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            fails++; $display("FAIL ra2_unused: stall_o=%b required 0", stall_o);
        end
        uses_ra2_d = 1'b1;
        #1;
        tests++;
        if (stall_o !== 1'b1) begin
            fails++; $display("FAIL ra2_used: stall_o=%b required 1", stall_o);
        end
    endtask

    task automatic test_xzr();
        do_reset();
        set_instr(5'd1, 5'd0, 1'b0, 5'd31, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd31, 5'd31, 1'b1, 5'd6, 3'b000, 3'b000, 2'b10, 1'b1);
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            fails++; $display("FAIL xzr_stall: stall_o=%b required 0", stall_o);
        end
        step();
        tests++;
        if (stall_cnt !== 4'd0 || valid_e !== 1'b1) begin
            fails++; $display("FAIL xzr_flow: cnt=%0d v=%b required 0 1", stall_cnt, valid_e);
        end
    endtask

    task automatic test_flush_priority();
        do_reset();
        set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd5, 5'd7, 1'b1, 5'd6, 3'b010, 3'b001, 2'b10, 1'b1);
        flush_i = 1'b1;
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            fails++; $display("FAIL flush_stall: stall_o=%b required 0", stall_o);
        end
        step();
        tests++;
        if ({ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e} !== 9'd0 || stall_cnt !== 4'd0) begin
            fails++;
            $display("FAIL flush_bubble: ctrl=%b cnt=%0d required 0 0", {ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e}, stall_cnt);
        end
        flush_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd5, 5'd0, 1'b0, 5'd6, 3'b100, 3'b010, 2'b11, 1'b1);
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++;
            if (stall_o !== (k == 0)) begin
                fails++; $display("FAIL b2b_load%0d: stall_o=%b required %b", k, stall_o, (k == 0));
            end
            step();
        end
        set_instr(5'd9, 5'd6, 1'b1, 5'd7, 3'b000, 3'b000, 2'b10, 1'b1);
        #1;
        tests++;
        if (stall_o !== 1'b1) begin
            fails++; $display("FAIL b2b_second: stall_o=%b required 1", stall_o);
        end
        step();
        step();
        tests++;
        if (stall_cnt !== 4'd2 || wa_e !== 5'd7 || valid_e !== 1'b1) begin
            fails++; $display("FAIL b2b_count: cnt=%0d wa=%0d v=%b required 2 7 1", stall_cnt, wa_e, valid_e);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd5, 5'd0, 1'b0, 5'd6, 3'b000, 3'b000, 2'b10, 1'b1);
        step();
        step();
        set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
        step();
        set_instr(5'd5, 5'd0, 1'b0, 5'd6, 3'b000, 3'b000, 2'b10, 1'b1);
        #1;
        tests++;
        if (stall_o !== 1'b1 || stall_cnt !== 4'd1) begin
            fails++; $display("FAIL rms_setup: stall_o=%b cnt=%0d required 1 1", stall_o, stall_cnt);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (stall_o !== 1'b0) begin
            fails++; $display("FAIL rms_stall: stall_o=%b required 0", stall_o);
        end
        step();
        tests++;
        if ({rd1_e, rd2_e, imm_e, ra1_e, ra2_e, wa_e, ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e, stall_cnt} !== '0) begin
            fails++;
            $display("FAIL rms_clear: got %h required 0", {rd1_e, rd2_e, imm_e, ra1_e, ra2_e, wa_e, ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e, stall_cnt});
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < CMAX + 4; i++) begin
            set_instr(5'd1, 5'd0, 1'b0, 5'd5, 3'b100, 3'b010, 2'b11, 1'b1);
            step();
            set_instr(5'd5, 5'd0, 1'b0, 5'd6, 3'b000, 3'b000, 2'b10, 1'b1);
            step();
            step();
            tests++;
            if (int'(stall_cnt) != ((i + 1 < CMAX) ? i + 1 : CMAX)) begin
                fails++;
                $display("FAIL sat_count%0d: cnt=%0d required %0d", i, stall_cnt, (i + 1 < CMAX) ? i + 1 : CMAX);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] pick[9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd31};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            set_instr(pick[$urandom_range(8)], pick[$urandom_range(8)], 1'($urandom),
                      pick[$urandom_range(8)], 3'($urandom), 3'($urandom), 2'($urandom),
                      ($urandom_range(9) < 8));
            flush_i = ($urandom_range(9) == 0);
            reset   = ($urandom_range(49) == 0);
            #1;
            tests++;
            if (stall_o !== model_stall()) begin
                fails++; $display("FAIL rnd_stall%0d: stall_o=%b required %b", i, stall_o, model_stall());
            end
            step();
            tests++;
            if ({rd1_e, rd2_e, imm_e, ra1_e, ra2_e, wa_e, ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e} !==
                {m_rd1, m_rd2, m_imm, m_ra1, m_ra2, m_wa, m_ex, m_mem, m_wb, m_valid}) begin
                fails++;
                $display("FAIL rnd_regs%0d: got %h required %h", i,
                         {rd1_e, rd2_e, imm_e, ra1_e, ra2_e, wa_e, ex_ctrl_e, mem_ctrl_e, wb_ctrl_e, valid_e},
                         {m_rd1, m_rd2, m_imm, m_ra1, m_ra2, m_wa, m_ex, m_mem, m_wb, m_valid});
            end
            tests++;
            if (int'(stall_cnt) != m_cnt) begin
                fails++; $display("FAIL rnd_cnt%0d: cnt=%0d required %0d", i, stall_cnt, m_cnt);
            end
        end
        reset = 1'b0;
        flush_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_instr(5'd0, 5'd0, 1'b0, 5'd0, 3'b000, 3'b000, 2'b00, 1'b0);
        test_reset();
        test_straight_line();
        test_load_use();
        test_ra2_gating();
        test_xzr();
        test_flush_priority();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
